// File: rtl/rng_pkg.sv
// Shared types and default sizes for the ring-oscillator sampling/conditioning path.
package rng_pkg;

  localparam int unsigned RNG_NUMBITS  = 32;
  localparam int unsigned RNG_WORDBITS = 32;

  typedef enum logic {
    VN_IDLE = 1'b0,
    VN_HAVE = 1'b1
  } vn_state_t;

endpackage

// File: rtl/rng_sync.sv
// Two-flop synchroniser bringing the free-running oscillator vector into the clk domain.
module rng_sync
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH = RNG_NUMBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/rng_sampler.sv
// Samples the synchronised oscillator vector, XOR-folds, von Neumann debiases,
// packs bits into words on a valid/ready port and runs a repetition-count health test.
module rng_sampler
  import rng_pkg::*;
#(
  parameter int unsigned NUMBITS    = RNG_NUMBITS,
  parameter int unsigned WORDBITS   = RNG_WORDBITS,
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned REP_LIMIT  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUMBITS-1:0]  raw_in,
  output logic [WORDBITS-1:0] rnd_data,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic                health_fail
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned BIT_W = $clog2(WORDBITS + 1);
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WORDBITS);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

  logic [NUMBITS-1:0]  sync;
  logic [DIV_W-1:0]    div_cnt;
  vn_state_t           state;
  logic                first;
  logic                prev_f;
  logic [WORDBITS-1:0] shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [REP_W-1:0]    rep_cnt;

  logic                strobe_c;
  logic                fold_c;
  logic                emit_c;
  logic                buf_free_c;
  logic                word_done_c;
  logic [WORDBITS-1:0] shreg_nxt_c;
  logic [BIT_W-1:0]    bit_cnt_nxt_c;
  logic [REP_W-1:0]    rep_nxt_c;

  rng_sync #(.WIDTH(NUMBITS)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (raw_in),
    .dout (sync)
  );

  // Strobe, debias decision, packer next-state and repetition counter next-state.
  always_comb begin
    strobe_c      = enable && (div_cnt == DIV_LAST);
    fold_c        = ^sync;
    emit_c        = strobe_c && (state == VN_HAVE) && (fold_c != first);
    buf_free_c    = !rnd_valid || rnd_ready;
    shreg_nxt_c   = shreg;
    bit_cnt_nxt_c = bit_cnt;
    rep_nxt_c     = rep_cnt;

    // A completed word parked in shreg blocks further bits until it drains.
    if (emit_c && (bit_cnt != BIT_FULL)) begin
      shreg_nxt_c   = {shreg[WORDBITS-2:0], first};
      bit_cnt_nxt_c = bit_cnt + BIT_W'(1);
    end
    word_done_c = (bit_cnt_nxt_c == BIT_FULL);

    if (strobe_c) begin
      if ((rep_cnt == '0) || (fold_c != prev_f)) begin
        rep_nxt_c = REP_W'(1);
      end else if (rep_cnt != REP_MAX) begin
        rep_nxt_c = rep_cnt + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      state       <= VN_IDLE;
      first       <= 1'b0;
      prev_f      <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
    end else begin
      if (rnd_valid && rnd_ready) begin
        rnd_valid <= 1'b0;
      end

      // Disabling resets the conditioning pipeline but keeps a pending word readable.
      if (!enable) begin
        div_cnt     <= '0;
        state       <= VN_IDLE;
        bit_cnt     <= '0;
        rep_cnt     <= '0;
        health_fail <= 1'b0;
      end else begin
        div_cnt <= strobe_c ? '0 : div_cnt + DIV_W'(1);

        if (strobe_c) begin
          prev_f <= fold_c;
          case (state)
            VN_IDLE: begin
              first <= fold_c;
              state <= VN_HAVE;
            end
            default: state <= VN_IDLE;
          endcase
          if (rep_nxt_c == REP_MAX) begin
            health_fail <= 1'b1;
          end
        end
        rep_cnt <= rep_nxt_c;

        shreg <= shreg_nxt_c;
        if (word_done_c && buf_free_c) begin
          rnd_data  <= shreg_nxt_c;
          rnd_valid <= 1'b1;
          bit_cnt   <= '0;
        end else begin
          bit_cnt <= bit_cnt_nxt_c;
        end
      end
    end
  end

endmodule

// File: doc/rng_sampler.md
# rng_sampler

Sampling and conditioning stage directly downstream of the ring-oscillator bank. It synchronises the free-running `NUMBITS`-wide oscillator vector into the system clock domain and samples it at a programmable rate. Each sample is XOR-folded to one bit, and the bit stream is debiased with a von Neumann corrector. The debiased bits are packed into `WORDBITS`-wide words and presented on a valid/ready interface to the register/AXI side. A sticky repetition-count health flag is also provided.

## Interface
Parameters:
- `NUMBITS`, 32: width of the raw oscillator vector.
- `WORDBITS`, 32: output word width.
- `SAMPLE_DIV`, 16: clock cycles between samples; must be ≥ 2.
- `REP_LIMIT`, 32: consecutive identical folded bits that trip the health flag; must be ≥ 2.

Ports:
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: sampling enable, synchronous to `clk`.
- `raw_in`, in, `NUMBITS`: asynchronous oscillator outputs.
- `rnd_data`, out, `WORDBITS`: conditioned random word.
- `rnd_valid`, out, 1: `rnd_data` holds an unread word.
- `rnd_ready`, in, 1: consumer accepts the word.
- `health_fail`, out, 1: sticky repetition-count failure.

## Operation
- **Synchroniser.** Two-flop synchroniser on every `raw_in` bit. `sync` is the second-stage value.
- **Sample divider.** `div_cnt` counts 0..`SAMPLE_DIV`-1 while `enable`=1. The sample strobe fires in the cycle where `div_cnt`==`SAMPLE_DIV`-1, and the counter then wraps to 0.
- **Fold.** At the strobe, `f` = XOR-reduction of `sync`.
- **Von Neumann FSM**, states `VN_IDLE` and `VN_HAVE`:
  - `VN_IDLE`, strobe: store `f` as `first`, go to `VN_HAVE`.
  - `VN_HAVE`, strobe:
    - If `f`≠`first`, emit bit `first`.
    - If `f`==`first`, emit nothing.
    - Either way, go to `VN_IDLE`.
- **Packer.**
  - Each emitted bit is shifted into the LSB of `shreg` (shift left), and `bit_cnt` increments. The first emitted bit ends up at the MSB.
  - When `bit_cnt`==`WORDBITS`, the word is complete.
  - If the output buffer is free (or being freed this cycle), `shreg` moves to `rnd_data`, `rnd_valid` sets and `bit_cnt` clears.
  - If the output buffer is still occupied, the completed word holds in `shreg`. Further emitted bits are discarded until the transfer happens.
- **Output handshake.**
  - A transfer occurs when `rnd_valid`&&`rnd_ready`.
  - `rnd_data` is stable while `rnd_valid`=1 and not accepted.
  - If a transfer and a completed word coincide, the new word loads in the same cycle and `rnd_valid` stays 1.
- **Health test.**
  - `rep_cnt` counts consecutive strobes with `f` equal to the previous `f`. It resets to 1 on any change.
  - On reaching `REP_LIMIT`, `health_fail` sets and stays set. Sampling continues.
- **`enable`=0 clears** `div_cnt`, the FSM (to `VN_IDLE`), `bit_cnt`, `rep_cnt` and `health_fail`.
- **`enable`=0 retains** `rnd_data`/`rnd_valid`, so a pending word can still be read.
- **Widths.**
  - `div_cnt`: $clog2(`SAMPLE_DIV`).
  - `bit_cnt`: $clog2(`WORDBITS`+1).
  - `rep_cnt`: $clog2(`REP_LIMIT`+1), saturating at `REP_LIMIT`.

## Timing
- **Reset values:** `rnd_data`=0, `rnd_valid`=0, `health_fail`=0. All internal state is 0 and the FSM is `VN_IDLE`.
- **`raw_in` to `sync`:** 2 cycles.
- **First strobe:** `SAMPLE_DIV` cycles after the first rising edge with `enable`=1.
- **Word output:** `rnd_valid` rises 1 cycle after the strobe that emits the `WORDBITS`-th bit, provided the buffer is free.
- **Best case:** 2·`WORDBITS` strobes per word.
- **`health_fail`:** rises 1 cycle after the strobe on which `rep_cnt` reaches `REP_LIMIT`.
- **Reset mid-word:** asynchronous; discards the partial word and any pending word immediately.

## Structure
- Package `rng_pkg`: `vn_state_t` enum (`VN_IDLE`, `VN_HAVE`) and default parameter constants `RNG_NUMBITS`, `RNG_WORDBITS`.
- Sub-module `rng_sync`: parameterised-width two-flop synchroniser with `clk`/`rst_n`, instantiated once for the vector.
- Everything else lives in `rng_sampler`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-operation. All outputs are 0 within the same cycle and remain 0 until enable plus 64 strobes.
- **Pairs (1,0):** `SAMPLE_DIV`=4; toggle `raw_in[0]` so the folded sequence is 1,0,1,0,… `rnd_data`=0xFFFFFFFF with `rnd_valid` after 64 strobes, i.e. cycle 2+64·4+1.
- **Pairs (0,1):** the sequence 0,1 repeated yields 0x00000000. The mixed sequence (1,0),(1,1),(0,1),… yields correct bit order, MSB first.
- **Backpressure:** hold `rnd_ready`=0 across 3 word times.
  - The first word stays stable.
  - The second word is held in `shreg`.
  - On `rnd_ready`=1 the first word transfers, and the second word appears the next cycle.
  - Bits produced during the stall are absent from the output.
- **Health:** hold `raw_in` constant. `health_fail`=1 after 32 strobes, and no word is produced. Dropping `enable` clears `health_fail`.
- **Enable drop mid-word:** 20 bits are collected, then `enable`=0. `bit_cnt` clears, the pending `rnd_valid` word is retained, and after re-enable a full 32 new bits are required.
